note_sequencer: RTL and testbench

Upstream stage of the song note ROM. Steps the ROM address `index` at a programmable tempo and absorbs the ROM's one-cycle read latency. Emits each step's 4-lane note pattern as a registered one-cycle spawn strobe to the falling-note/gameplay logic. Handles start, pause, speed select and end-of-song.

---
 rtl/note_sequencer.sv | 137 +++++++++++++
 tb/tb_note_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: steps the song ROM address at a programmable tempo, absorbs
// the ROM's one-cycle read latency and emits each step's 4-lane note pattern
// as a registered one-cycle spawn strobe.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   start        level-sampled; begins play from IDLE or DONE
//   pause        freezes the step timer while high (COUNT only)
//   speed_sel    tempo: 00 P=STEP_CYCLES, 01 P/2, 1x P/4
//   notes_in     ROM data, valid one cycle after index is presented
//   index        ROM address (registered)
//   spawn        lane bits of the current step, qualified by spawn_valid
//   spawn_valid  one-cycle pulse per step, rests included
//   playing      high in FETCH/LATCH/EMIT/COUNT
//   song_done    high in DONE
module note_sequencer #(
  parameter int unsigned STEP_CYCLES = 12500000,
  parameter int unsigned SONG_LEN    = 64,
  parameter int unsigned INDEX_W     = 6,
  parameter int unsigned CNT_W       = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         speed_sel,
  input  logic [3:0]         notes_in,
  output logic [INDEX_W-1:0] index,
  output logic [3:0]         spawn,
  output logic               spawn_valid,
  output logic               playing,
  output logic               song_done
);

  localparam logic [CNT_W-1:0]   P_FULL   = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0]   P_HALF   = CNT_W'(STEP_CYCLES >> 1);
  localparam logic [CNT_W-1:0]   P_QUART  = CNT_W'(STEP_CYCLES >> 2);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_EMIT, S_COUNT, S_DONE
  } state_e;

  state_e             state_q;
  logic [INDEX_W-1:0] index_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   period_d;
  logic [3:0]         spawn_q;
  logic               spawn_valid_q;
  logic               playing_q;
  logic               song_done_q;
  logic               cnt_exit;

  always_comb begin
    period_d = P_QUART;
    unique case (speed_sel)
      2'b00:   period_d = P_FULL;
      2'b01:   period_d = P_HALF;
      default: period_d = P_QUART;
    endcase
  end

  // FETCH, LATCH and EMIT take three of the P cycles, so COUNT runs P-3
  // cycles (counter 0..P-4) to make consecutive strobes exactly P apart.
  assign cnt_exit = (cnt_q == (period_q - CNT_W'(4)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      cnt_q         <= '0;
      period_q      <= P_FULL;
      spawn_q       <= '0;
      spawn_valid_q <= 1'b0;
      playing_q     <= 1'b0;
      song_done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_FETCH;
            index_q     <= '0;
            period_q    <= period_d;
            playing_q   <= 1'b1;
            song_done_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          // ROM data for index is valid now; capture it as the strobe.
          state_q       <= S_EMIT;
          spawn_q       <= notes_in;
          spawn_valid_q <= 1'b1;
        end
        S_EMIT: begin
          // Tempo changes are only picked up here, so a step in progress
          // always keeps the gap it started with.
          state_q       <= S_COUNT;
          spawn_valid_q <= 1'b0;
          period_q      <= period_d;
          cnt_q         <= '0;
        end
        S_COUNT: begin
          if (!pause) begin
            if (cnt_exit) begin
              if (index_q == LAST_IDX) begin
                state_q     <= S_DONE;
                playing_q   <= 1'b0;
                song_done_q <= 1'b1;
              end else begin
                state_q <= S_FETCH;
                index_q <= index_q + INDEX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          spawn_valid_q <= 1'b0;
          playing_q     <= 1'b0;
          song_done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign index       = index_q;
  assign spawn       = spawn_q;
  assign spawn_valid = spawn_valid_q;
  assign playing     = playing_q;
  assign song_done   = song_done_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  localparam int STEP = 16;
  localparam int LEN  = 4;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pause;
  logic [1:0]    speed_sel;
  logic [3:0]    notes_in;
  logic [IW-1:0] index;
  logic [3:0]    spawn;
  logic          spawn_valid;
  logic          playing;
  logic          song_done;

  logic [3:0] rom [8];
  int checks = 0;
  int errors = 0;

  note_sequencer #(.STEP_CYCLES(STEP), .SONG_LEN(LEN), .INDEX_W(IW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .speed_sel(speed_sel),
    .notes_in(notes_in), .index(index), .spawn(spawn), .spawn_valid(spawn_valid),
    .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Song ROM with one-cycle read latency.
  always @(posedge clk) notes_in <= rom[index];

  // Reference model: per step, "age" counts cycles relative to that step's
  // strobe (-2 fetch, -1 latch, 0 strobe, 1..P-3 paused-able wait), where P is
  // the tempo selected in the strobe cycle.
  int         m_mode;   // 0 idle, 1 playing, 2 done
  int         m_step;
  int         m_age;
  int         m_p;
  logic [3:0] m_spawn;

  function automatic int period_of(logic [1:0] s);
    if (s == 2'b00) return STEP;
    if (s == 2'b01) return STEP / 2;
    return STEP / 4;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_age = 0; m_p = STEP; m_spawn = 4'b0;
  endtask

  task automatic model_clock();
    if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_step = 0; m_age = -2; end
    end else if (m_age < 0) begin
      m_age++;
      if (m_age == 0) m_spawn = rom[m_step];
    end else if (m_age == 0) begin
      m_p = period_of(speed_sel);
      m_age = 1;
    end else if (!pause) begin
      if (m_age == m_p - 3) begin
        if (m_step == LEN - 1) m_mode = 2;
        else begin m_step++; m_age = -2; end
      end else m_age++;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("index",       int'(index),       m_step);
    check("spawn_valid", int'(spawn_valid), (m_mode == 1 && m_age == 0) ? 1 : 0);
    check("spawn",       int'(spawn),       int'(m_spawn));
    check("playing",     int'(playing),     (m_mode == 1) ? 1 : 0);
    check("song_done",   int'(song_done),   (m_mode == 2) ? 1 : 0);
  endtask

  // One clock: update the model from the inputs sampled at the edge, compare
  // just after, then return at the falling edge ready for new inputs.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_clock(); else model_reset();
    #1 compare_all();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; speed_sel = 2'b00;
    rom[0] = 4'b0010; rom[1] = 4'b0000; rom[2] = 4'b1000; rom[3] = 4'b0101;
    for (int i = 4; i < 8; i++) rom[i] = 4'b1111;
    model_reset();
    #2 compare_all();
    repeat (2) cycle();
    reset = 1'b1;
    repeat (20) cycle();

    // Basic play at full period to completion.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (75) cycle();

    // Quarter speed, start held through the whole song.
    speed_sel = 2'b10; start = 1'b1;
    repeat (25) cycle();
    start = 1'b0; speed_sel = 2'b00;
    repeat (5) cycle();

    // Restart with a mid-count speed change and a pause burst.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    speed_sel = 2'b01; pause = 1'b1;
    repeat (5) cycle();
    pause = 1'b0;
    repeat (50) cycle();

    // Async reset in the middle of a step, then replay.
    start = 1'b1; cycle(); start = 1'b0;
    repeat (40) cycle();
    #2 reset = 1'b0;
    #1 model_reset(); compare_all();
    @(negedge clk);
    cycle();
    reset = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (10) cycle();

    // Randomised phase with fresh ROM contents.
    for (int i = 0; i < 4; i++) rom[i] = 4'($urandom_range(0, 15));
    repeat (80) cycle();
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) speed_sel = 2'($urandom_range(0, 3));
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #1 model_reset(); compare_all();
        @(negedge clk);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
